// File: rtl/adc_sample_ctrl_pkg.sv
// Shared types and defaults for the serial ADC sample sequencer.
package adc_sample_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_QUIET = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  localparam int unsigned CLK_DIV_DEF       = 5;
  localparam int unsigned NEDGES_DEF        = 17;
  localparam int unsigned QUIET_EDGES_DEF   = 2;
  localparam int unsigned SAMPLE_PERIOD_DEF = 2500;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned SAMPLE_W = 12;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_sample_ctrl_if.sv
// Control, ADC pin and sample-delivery signals of the ADC sample sequencer.
interface adc_sample_ctrl_if;
  import adc_sample_ctrl_pkg::*;

  logic                enable;
  logic                cont;
  logic                start;
  logic [DATA_W-1:0]   data_in;
  logic                CS;
  logic                SCLK;
  logic [SAMPLE_W-1:0] sample;
  logic                sample_valid;
  logic                fmt_err;
  logic                busy;
  logic                overrun;

  modport master (
    input  enable, cont, start, data_in,
    output CS, SCLK, sample, sample_valid, fmt_err, busy, overrun
  );

  modport slave (
    output enable, cont, start, data_in,
    input  CS, SCLK, sample, sample_valid, fmt_err, busy, overrun
  );

endinterface

// File: rtl/adc_sample_ctrl_sclk_gen.sv
// SCLK divider: toggles SCLK every CLK_DIV clocks while run_i, idles high otherwise.
module adc_sample_ctrl_sclk_gen
  import adc_sample_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic sclk_o,
  output logic fall_o,
  output logic rise_o
);

  localparam int unsigned     DW       = cnt_w(CLK_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          tgl;

  always_comb begin
    tgl    = run_i && (div_q == DIV_LAST);
    div_d  = '0;
    sclk_d = 1'b1;
    if (run_i) begin
      div_d  = tgl ? '0 : div_q + 1'b1;
      sclk_d = tgl ? ~sclk_q : sclk_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign fall_o = tgl & sclk_q;
  assign rise_o = tgl & ~sclk_q;

endmodule

// File: rtl/adc_sample_ctrl.sv
// Serial ADC frame sequencer: CS/SCLK framing, period timer, sample capture.
module adc_sample_ctrl
  import adc_sample_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV       = CLK_DIV_DEF,
  parameter int unsigned NEDGES        = NEDGES_DEF,
  parameter int unsigned QUIET_EDGES   = QUIET_EDGES_DEF,
  parameter int unsigned SAMPLE_PERIOD = SAMPLE_PERIOD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  adc_sample_ctrl_if.master bus
);

  localparam int unsigned   EMAX       = (NEDGES > QUIET_EDGES) ? NEDGES : QUIET_EDGES;
  localparam int unsigned   EW         = cnt_w(EMAX + 1);
  localparam int unsigned   TW         = cnt_w(SAMPLE_PERIOD);
  localparam logic [EW-1:0] SHIFT_LAST = EW'(NEDGES);
  localparam logic [EW-1:0] QUIET_LAST = EW'(QUIET_EDGES);
  localparam logic [TW-1:0] TMR_LAST   = TW'(SAMPLE_PERIOD - 1);

  state_e              state_q, state_d;
  logic [EW-1:0]       edge_q, edge_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                pend_q, pend_d;
  logic                ovr_q, ovr_d;
  logic                cap_q, cs_q, busy_q, valid_q, fmt_q;
  logic [SAMPLE_W-1:0] sample_q;
  logic                run, sclk, fall, rise, launch, expire;

  assign run = (state_q == ST_SHIFT) || (state_q == ST_QUIET);

  adc_sample_ctrl_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk    (clk),
    .reset  (reset),
    .run_i  (run),
    .sclk_o (sclk),
    .fall_o (fall),
    .rise_o (rise)
  );

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    launch  = 1'b0;
    expire  = (state_q != ST_IDLE) && (tmr_q == TMR_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.enable && (bus.cont || bus.start)) begin
          state_d = ST_SHIFT;
          launch  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (fall) edge_d = edge_q + 1'b1;
        if (rise && (edge_q == SHIFT_LAST)) begin
          state_d = ST_QUIET;
          edge_d  = '0;
        end
      end
      ST_QUIET: begin
        if (fall) edge_d = edge_q + 1'b1;
        if (rise && (edge_q == QUIET_LAST)) begin
          edge_d = '0;
          if (!bus.enable || !bus.cont) begin
            state_d = ST_IDLE;
          end else if (pend_q || expire) begin
            state_d = ST_SHIFT;
            launch  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.enable || !bus.cont) begin
          state_d = ST_IDLE;
        end else if (expire) begin
          state_d = ST_SHIFT;
          launch  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An expiry that coincides with QUIET exit launches directly and only flags overrun.
    if (expire && run) begin
      ovr_d  = 1'b1;
      pend_d = !launch;
    end
    if (launch || (state_d == ST_IDLE)) pend_d = 1'b0;
    if ((state_q == ST_IDLE) && launch) ovr_d = 1'b0;
    if (!bus.enable) ovr_d = 1'b0;

    tmr_d = (launch || expire || (state_d == ST_IDLE)) ? '0 : tmr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      edge_q   <= '0;
      tmr_q    <= '0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      cap_q    <= 1'b0;
      cs_q     <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      fmt_q    <= 1'b0;
      sample_q <= '0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      cap_q   <= (state_q == ST_SHIFT) && (state_d == ST_QUIET);
      cs_q    <= (state_d != ST_SHIFT);
      busy_q  <= (state_d == ST_SHIFT) || (state_d == ST_QUIET);
      valid_q <= cap_q;
      fmt_q   <= cap_q && (bus.data_in[DATA_W-1:SAMPLE_W] != '0);
      if (cap_q) sample_q <= bus.data_in[SAMPLE_W-1:0];
    end
  end

  assign bus.CS           = cs_q;
  assign bus.SCLK         = sclk;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.fmt_err      = fmt_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench for adc_sample_ctrl with an ADC pin model and shift receiver per instance.
module tb_adc_sample_ctrl;
  import adc_sample_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adc_sample_ctrl_if ba ();
  adc_sample_ctrl_if bb ();

  adc_sample_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ba.master)
  );

  adc_sample_ctrl #(.SAMPLE_PERIOD(100)) u_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (bb.master)
  );

  int nchk  = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ADC + receiver: first CS-low fall is the detect edge, then 16 bits MSB first.
  logic [15:0] word_a = '0, word_b = '0, rx_a = '0, rx_b = '0;
  int fcnt_a = 0, fcnt_b = 0, falls_a = 0;

  always @(negedge ba.CS) fcnt_a = 0;
  always @(posedge ba.CS) falls_a = fcnt_a;
  always @(negedge ba.SCLK) if (ba.CS === 1'b0) begin
    if (fcnt_a >= 1 && fcnt_a <= 16) rx_a = {rx_a[14:0], word_a[16-fcnt_a]};
    fcnt_a++;
  end
  always @(negedge bb.CS) fcnt_b = 0;
  always @(negedge bb.SCLK) if (bb.CS === 1'b0) begin
    if (fcnt_b >= 1 && fcnt_b <= 16) rx_b = {rx_b[14:0], word_b[16-fcnt_b]};
    fcnt_b++;
  end
  assign ba.data_in = rx_a;
  assign bb.data_in = rx_b;

  int cyc = 0;
  int nval_a = 0;
  int va_t[$];
  int vb_t[$];
  always @(posedge clk) begin
    if (ba.sample_valid === 1'b1) begin
      va_t.push_back(cyc);
      nval_a++;
    end
    if (bb.sample_valid === 1'b1) vb_t.push_back(cyc);
    cyc++;
  end

  // Leaves the bench at the negedge of SHIFT cycle 0.
  task automatic pulse_start_a();
    ba.start = 1'b1;
    @(negedge clk);
    ba.start = 1'b0;
  endtask

  initial begin
    int n;
    int w;

    ba.enable = 1'b0; ba.cont = 1'b0; ba.start = 1'b0;
    bb.enable = 1'b0; bb.cont = 1'b0; bb.start = 1'b0;
    word_b = 16'h0777;
    reset  = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("por_cs",     ba.CS, 1);
    chk("por_sclk",   ba.SCLK, 1);
    chk("por_sample", ba.sample, 0);
    chk("por_valid",  ba.sample_valid, 0);
    chk("por_fmt",    ba.fmt_err, 0);
    chk("por_busy",   ba.busy, 0);
    chk("por_ovr",    ba.overrun, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Single shot, 0x0ABC; a start mid-frame must be ignored.
    word_a = 16'h0ABC;
    ba.enable = 1'b1;
    pulse_start_a();
    chk("t2_cs_fall", ba.CS, 0);
    n = 0;
    while (ba.CS === 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 100) ba.start = 1'b1;
      if (n == 101) ba.start = 1'b0;
    end
    chk("t2_cs_low_len", n, 170);
    chk("t2_falls", falls_a, 17);
    chk("t2_valid_at_cs_rise", ba.sample_valid, 0);
    chk("t2_busy_quiet", ba.busy, 1);
    @(negedge clk);
    chk("t2_valid", ba.sample_valid, 1);
    chk("t2_sample", ba.sample, 12'hABC);
    chk("t2_fmt", ba.fmt_err, 0);
    @(negedge clk);
    chk("t2_valid_pulse", ba.sample_valid, 0);
    repeat (17) @(negedge clk);
    chk("t2_busy_189", ba.busy, 1);
    @(negedge clk);
    chk("t2_busy_190", ba.busy, 0);
    chk("t2_sclk_end", ba.SCLK, 1);
    repeat (60) @(negedge clk);
    chk("t2_start_ignored", ba.CS, 1);
    chk("t2_one_valid", nval_a, 1);

    // Asynchronous reset while idle clears the held sample before any edge.
    #2 reset = 1'b0;
    #1;
    chk("t1_idle_sample", ba.sample, 0);
    chk("t1_idle_cs", ba.CS, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Reset during SHIFT (SCLK low phase around clk 57), then a clean frame.
    word_a = 16'h0555;
    pulse_start_a();
    repeat (57) @(negedge clk);
    chk("t5_sclk_low", ba.SCLK, 0);
    chk("t5_cs_low", ba.CS, 0);
    #2 reset = 1'b0;
    #1;
    chk("t5_cs_reset", ba.CS, 1);
    chk("t5_sclk_reset", ba.SCLK, 1);
    chk("t5_busy_reset", ba.busy, 0);
    w = nval_a;
    repeat (200) @(negedge clk);
    chk("t5_no_valid", nval_a, w);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start_a();
    n = 0;
    while (ba.CS === 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("t5_cs_low_len", n, 170);
    @(negedge clk);
    chk("t5_valid", ba.sample_valid, 1);
    chk("t5_sample", ba.sample, 12'h555);
    repeat (25) @(negedge clk);

    // Continuous sampling: 2500-clk spacing, no overrun.
    word_a = 16'h0123;
    va_t.delete();
    ba.cont = 1'b1;
    n = 0;
    while (va_t.size() < 5 && n < 14000) begin
      @(negedge clk);
      n++;
    end
    chk("t3_frames", va_t.size(), 5);
    for (int i = 1; i < va_t.size(); i++) chk("t3_spacing", va_t[i] - va_t[i-1], 2500);
    chk("t3_overrun", ba.overrun, 0);
    chk("t3_sample", ba.sample, 12'h123);
    ba.cont = 1'b0;
    repeat (300) @(negedge clk);
    chk("t3_back_idle_cs", ba.CS, 1);
    chk("t3_back_idle_busy", ba.busy, 0);

    // Enable dropped mid-SHIFT: frame completes, format error flagged, then idle.
    word_a = 16'hF123;
    pulse_start_a();
    n = 0;
    while (ba.CS === 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 50) ba.enable = 1'b0;
    end
    chk("t6_cs_low_len", n, 170);
    @(negedge clk);
    chk("t6_valid", ba.sample_valid, 1);
    chk("t6_sample", ba.sample, 12'h123);
    chk("t6_fmt", ba.fmt_err, 1);
    @(negedge clk);
    chk("t6_fmt_pulse", ba.fmt_err, 0);
    w = nval_a;
    ba.start = 1'b1;
    repeat (2) @(negedge clk);
    ba.start = 1'b0;
    repeat (250) @(negedge clk);
    chk("t6_idle_cs", ba.CS, 1);
    chk("t6_idle_busy", ba.busy, 0);
    chk("t6_no_more_valid", nval_a, w);

    // Short period instance: overrun and back-to-back 190-clk frames.
    vb_t.delete();
    bb.enable = 1'b1;
    bb.cont   = 1'b1;
    n = 0;
    while (vb_t.size() < 1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("t4_first_frame", vb_t.size(), 1);
    chk("t4_overrun_set", bb.overrun, 1);
    chk("t4_sample", bb.sample, 12'h777);
    n = 0;
    while (vb_t.size() < 4 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t4_frames", vb_t.size(), 4);
    for (int i = 1; i < vb_t.size(); i++) chk("t4_spacing", vb_t[i] - vb_t[i-1], 190);
    bb.enable = 1'b0;
    @(negedge clk);
    chk("t4_overrun_clear", bb.overrun, 0);
    repeat (250) @(negedge clk);
    chk("t4_idle_busy", bb.busy, 0);
    chk("t4_default_no_ovr", ba.overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
